// File: rtl/jbc_translator.sv
// Translates one Java bytecode into 1..MAX_UOPS micro-op words streamed out over valid/ready.
// Optional feature: define JBC_TRAP_EN to emit a trap word for unknown opcodes.
module jbc_translator #(
  parameter int                BYTE      = 8,
  parameter int                IN_W      = 16,
  parameter int                OUT_W     = 32,
  parameter int                ADDR_W    = 16,
  parameter int                MAX_UOPS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [IN_W-1:0]   instr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              illegal,
  output logic [1:0]        dbg_state
);

  // Handshake: a word moves on any rising edge where out_valid & out_ready are both 1;
  // while out_valid=1 and out_ready=0, out_data/out_addr hold their values.
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EMIT, S_DONE} state_t;

  state_t              r_state;
  logic [IN_W-1:0]     r_instr;
  logic [3:0]          r_n;
  logic [3:0]          r_k;
  logic                r_trap;
  logic                r_ready;
  logic                r_valid;
  logic [OUT_W-1:0]    r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_done;
  logic                r_illegal;

  logic [BYTE-1:0]     w_op;
  logic [BYTE-1:0]     w_operand;
  logic [3:0]          w_cnt;
  logic [3:0]          w_n;
  logic                w_xfer;

  function automatic logic [3:0] f_table(input logic [7:0] op);
    case (op)
      8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
      8'h26, 8'h27, 8'h28, 8'h29:                                     f_table = 4'd1;
      8'h60, 8'h7E, 8'h80, 8'h70, 8'h78, 8'h85, 8'h86, 8'h87,
      8'h91, 8'h92, 8'h93, 8'h88, 8'h89, 8'h8A:                       f_table = 4'd2;
      8'h61, 8'h7F, 8'h94, 8'h6B, 8'h6F, 8'h73, 8'h77:                f_table = 4'd3;
      8'h18, 8'h2E, 8'h2F, 8'h4F, 8'h50, 8'hAC, 8'hAF:                f_table = 4'd4;
      default:                                                        f_table = 4'd0;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] f_word(input logic [BYTE-1:0] op,
                                              input logic [BYTE-1:0] opnd,
                                              input logic [3:0] k, input logic [3:0] n);
    logic [OUT_W-1:0] w;
    w = '0;
    w[OUT_W-1 -: BYTE]      = op;
    w[OUT_W-BYTE-1 -: BYTE] = opnd;
    w[2*BYTE-1:BYTE]        = BYTE'(k);
    w[BYTE-1:0]             = BYTE'(n);
    return w;
  endfunction

  assign w_op      = r_instr[IN_W-1 -: BYTE];
  assign w_operand = r_instr[BYTE-1:0];
  assign w_cnt     = f_table(8'(w_op));
  assign w_n       = (w_cnt > 4'(MAX_UOPS)) ? 4'(MAX_UOPS) : w_cnt;
  assign w_xfer    = r_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_trap    <= 1'b0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_addr    <= BASE_ADDR;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_instr <= instr_in;
            r_ready <= 1'b0;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_k <= '0;
          if (w_n == 4'd0) begin
`ifdef JBC_TRAP_EN
            r_n     <= 4'd1;
            r_trap  <= 1'b1;
            r_data  <= f_word({BYTE{1'b1}}, w_op, 4'd0, 4'd1);
            r_valid <= 1'b1;
            r_state <= S_EMIT;
`else
            r_n       <= '0;
            r_trap    <= 1'b0;
            r_done    <= 1'b1;
            r_illegal <= 1'b1;
            r_state   <= S_DONE;
`endif
          end else begin
            r_n     <= w_n;
            r_trap  <= 1'b0;
            r_data  <= f_word(w_op, w_operand, 4'd0, w_n);
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            r_addr <= r_addr + 1'b1;
            if (r_k == r_n - 4'd1) begin
              r_valid   <= 1'b0;
              r_done    <= 1'b1;
              r_illegal <= r_trap;
              r_state   <= S_DONE;
            end else begin
              r_k    <= r_k + 4'd1;
              r_data <= f_word(w_op, w_operand, r_k + 4'd1, r_n);
            end
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_addr  = r_addr;
  assign done      = r_done;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

endmodule
